sequenciador_busca: RTL and testbench
=====================================

Name: sequenciador_busca

Overview:
- Fetch/sequencing FSM that drives the decoder-side control unit. It fetches an instruction word from instruction memory over a req/ack handshake and presents the opcode and LSB fields to the control unit.
- It samples the decoded halt/jump/beq back from the control unit and computes the next PC.
- It qualifies each executed instruction with a one-cycle commit strobe, so the single-cycle datapath becomes a fetch/execute machine tolerant of variable-latency memory.

Parameters:
- PC_W, 5, PC and instruction-address width; PC arithmetic is modulo 2^PC_W.
- INSTR_W, 8, instruction word width. Fields: opcode = [7:5], bit_menos_sig = [0], jump target = [PC_W-1:0], beq offset = [2:0] (signed).
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT, 15, maximum BUSCA wait cycles before a fault. Used only with SEQ_TIMEOUT_EN.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high in BUSCA.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  memory returns imem_dado valid this cycle. Ignored unless imem_req=1.
- imem_dado  in  INSTR_W  instruction word.
- OPcode  out  3  registered instr[7:5] to the control unit.
- bit_menos_sig  out  1  registered instr[0] to the control unit.
- halt  in  1  from the control unit.
- jump  in  1  from the control unit.
- beq  in  1  from the control unit.
- zero  in  1  ALU zero flag from the datapath.
- exec_valid  out  1  one-cycle commit strobe; the datapath writes state only when high.
- pc  out  PC_W  current PC.
- parado  out  1  high in PARADO.
- retomar  in  1  leave PARADO.
- instr_count  out  CNT_W  retired instruction count.
- erro_timeout  out  1  fetch-timeout fault flag.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=BUSCA, pc=0, instr register=0 (so OPcode=000, bit_menos_sig=0).
  - exec_valid=0, instr_count=0, erro_timeout=0.
  - imem_req=1 from the first clock after release.
- BUSCA:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1, capture imem_dado into the instr register and go to EXECUTA next cycle; otherwise stay.
  - Zero-wait memory gives 2 cycles per instruction.
- EXECUTA (exactly one cycle):
  - imem_req=0, exec_valid=1.
  - instr_count increments, saturating at 2^CNT_W-1.
  - Next PC, by priority:
    1. halt: pc=pc+1, go to PARADO.
    2. jump: pc=instr[PC_W-1:0], go to BUSCA.
    3. beq and zero: pc=pc+1+sext(instr[2:0]), go to BUSCA.
    4. otherwise: pc=pc+1, go to BUSCA.
- PARADO:
  - parado=1, imem_req=0, exec_valid=0.
  - retomar=1 goes to BUSCA at the held pc; otherwise stay.
  - retomar is ignored in every other state.
- Boundaries:
  - PC wraps: 31+1 = 0; a beq offset of -4 from pc=1 gives pc=30.
  - imem_ack in EXECUTA or PARADO is ignored.
  - halt together with jump/beq: halt wins.
  - Asserting reset mid-fetch abandons the fetch; imem_req drops asynchronously.
- Outputs are registered or state-decoded only; no combinational path from halt/jump/beq/zero to any output.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on BUSCA entry and increments each BUSCA cycle without ack.
  - When it reaches TIMEOUT, go to PARADO with erro_timeout=1 sticky (no exec_valid, pc unchanged).
  - erro_timeout clears only on reset; retomar still resumes.
- Undefined: no counter; erro_timeout is tied to 0; BUSCA waits indefinitely.

Decomposition:
- Package sequenciador_pkg holds:
  - State encoding: BUSCA=2'd0, EXECUTA=2'd1, PARADO=2'd2.
  - Instruction field bit positions.
  - OPcode constants: ADD=3'd0, BEQ=3'd2, LW=3'd3.
- One sub-module: calc_prox_pc, combinational next-PC mux (halt/jump/beq priority, sign extension, modulo wrap).

Test Plan:
- Reset, zero-wait ack, memory holds 8'h00 at addr 0 → imem_req at cycle 1, exec_valid at cycle 2, pc=1, instr_count=1, OPcode=000.
- Ack delayed 3 cycles at pc=4 → imem_req held high for 4 cycles at imem_addr=4; one exec_valid pulse; no double capture.
- Instr 8'h4D with jump=1 at pc=2 → pc=13. Instr with beq=1, zero=1, offset 3'b100 at pc=1 → pc=30. Same with zero=0 → pc=2.
- Instr 8'h01 with halt=1 and jump=1 at pc=7 → parado=1, pc=8, imem_req=0 for 10 cycles; retomar pulse → fetch at addr 8.
- Reset_n pulled low during BUSCA wait → imem_req=0 and pc=0 immediately; clean restart fetching addr 0.
- With SEQ_TIMEOUT_EN, no ack → after 15 BUSCA cycles parado=1, erro_timeout=1, exec_valid never asserted.

Source files
------------

// File: rtl/sequenciador_pkg.sv
// ---------------------------------------------------------------------------
// sequenciador_pkg
// Shared definitions for the fetch/sequencing unit: FSM state encoding,
// instruction field bit positions and the opcode values the control unit
// decodes.
// ---------------------------------------------------------------------------
package sequenciador_pkg;

  // FSM states of the fetch/execute sequencer
  typedef enum logic [1:0] {
    BUSCA   = 2'd0,
    EXECUTA = 2'd1,
    PARADO  = 2'd2
  } estado_t;

  // Instruction field bit positions (8-bit instruction word)
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int LSB_BIT = 0;
  localparam int OFF_MSB = 2;

  // Opcode values seen by the control unit
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_BEQ = 3'd2;
  localparam logic [2:0] OP_LW  = 3'd3;

endpackage

// File: rtl/calc_prox_pc.sv
// ---------------------------------------------------------------------------
// calc_prox_pc
// Combinational next-PC selector. Priority: halt > jump > taken beq > pc+1.
// All arithmetic wraps modulo 2^PC_W.
// Ports:
//   pc_i      current PC
//   campo_i   low PC_W bits of the instruction (jump target / beq offset)
//   halt_i, jump_i, beq_i, zero_i   decoded control and ALU zero flag
//   prox_pc_o next PC
// ---------------------------------------------------------------------------
module calc_prox_pc
  import sequenciador_pkg::*;
#(
  parameter int PC_W = 5
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] campo_i,
  input  logic            halt_i,
  input  logic            jump_i,
  input  logic            beq_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] prox_pc_o
);

  logic [PC_W-1:0] pc_mais1_s;
  logic [PC_W-1:0] desloc_s;

  // Sign-extend the 3-bit beq offset and form pc+1
  always_comb begin
    pc_mais1_s = pc_i + PC_W'(1);
    desloc_s   = {{(PC_W-OFF_MSB-1){campo_i[OFF_MSB]}}, campo_i[OFF_MSB:0]};
  end

  // Priority mux; halt still advances past the halting instruction
  always_comb begin
    prox_pc_o = pc_mais1_s;
    if (halt_i) begin
      prox_pc_o = pc_mais1_s;
    end else if (jump_i) begin
      prox_pc_o = campo_i;
    end else if (beq_i && zero_i) begin
      prox_pc_o = pc_mais1_s + desloc_s;
    end else begin
      prox_pc_o = pc_mais1_s;
    end
  end

endmodule

// File: rtl/sequenciador_busca.sv
// ---------------------------------------------------------------------------
// sequenciador_busca
// Fetch/execute sequencer in front of a single-cycle datapath. Fetches an
// instruction over a req/ack handshake (BUSCA), presents OPcode and
// bit_menos_sig to the control unit for one commit cycle (EXECUTA) and
// computes the next PC from halt/jump/beq/zero. PARADO holds until retomar.
// Optional feature: define SEQ_TIMEOUT_EN to enable the fetch-timeout fault.
// Ports:
//   clock, reset_n            clock, async active-low reset
//   imem_req/addr/ack/dado    instruction memory handshake
//   OPcode, bit_menos_sig     registered instruction fields to control unit
//   halt, jump, beq, zero     decoded control and ALU zero flag
//   exec_valid                one-cycle commit strobe
//   pc, parado, retomar       current PC, halted flag, resume request
//   instr_count               saturating retired-instruction counter
//   erro_timeout              sticky fetch-timeout fault
// ---------------------------------------------------------------------------
module sequenciador_busca
  import sequenciador_pkg::*;
#(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_dado,
  output logic [2:0]         OPcode,
  output logic               bit_menos_sig,
  input  logic               halt,
  input  logic               jump,
  input  logic               beq,
  input  logic               zero,
  output logic               exec_valid,
  output logic [PC_W-1:0]    pc,
  output logic               parado,
  input  logic               retomar,
  output logic [CNT_W-1:0]   instr_count,
  output logic               erro_timeout
);

  estado_t            state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    prox_pc_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               erro_q, erro_d;
`endif

  calc_prox_pc #(.PC_W(PC_W)) u_calc_prox_pc (
    .pc_i      (pc_q),
    .campo_i   (instr_q[PC_W-1:0]),
    .halt_i    (halt),
    .jump_i    (jump),
    .beq_i     (beq),
    .zero_i    (zero),
    .prox_pc_o (prox_pc_s)
  );

  // Next-state logic; imem_req is registered so it is low during reset and
  // rises on the first clock after release (acks are ignored until then)
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
`ifdef SEQ_TIMEOUT_EN
    wait_d  = wait_q;
    erro_d  = erro_q;
`endif
    case (state_q)
      BUSCA: begin
        if (req_q && imem_ack) begin
          instr_d = imem_dado;
          state_d = EXECUTA;
`ifdef SEQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (req_q) begin
            if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
              state_d = PARADO;
              erro_d  = 1'b1;
              wait_d  = '0;
            end else begin
              wait_d  = wait_q + WAIT_W'(1);
            end
          end else begin
            wait_d = wait_q;
          end
`else
          state_d = BUSCA;
`endif
        end
      end
      EXECUTA: begin
        pc_d = prox_pc_s;
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          count_d = count_q;
        end
        if (halt) begin
          state_d = PARADO;
        end else begin
          state_d = BUSCA;
        end
      end
      PARADO: begin
        if (retomar) begin
          state_d = BUSCA;
        end else begin
          state_d = PARADO;
        end
      end
      default: begin
        state_d = BUSCA;
      end
    endcase
    req_d = (state_d == BUSCA);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BUSCA;
      pc_q    <= '0;
      instr_q <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Fetch wait counter and sticky timeout flag (cleared only by reset)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
      erro_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      erro_q <= erro_d;
    end
  end
  assign erro_timeout = erro_q;
`else
  assign erro_timeout = 1'b0;
`endif

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign OPcode        = instr_q[OPC_MSB:OPC_LSB];
  assign bit_menos_sig = instr_q[LSB_BIT];
  assign instr_count   = count_q;
  assign exec_valid    = (state_q == EXECUTA);
  assign parado        = (state_q == PARADO);

endmodule

// File: tb/tb_sequenciador_busca.sv
// Self-checking bench for sequenciador_busca: a scoreboard queue receives the
// expected commit fields whenever an instruction is handed to the DUT, and a
// monitor pops and compares them on every exec_valid pulse.
module tb_sequenciador_busca;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_dado;
  logic [2:0]  OPcode;
  logic        bit_menos_sig;
  logic        halt, jump, beq, zero;
  logic        exec_valid;
  logic [4:0]  pc;
  logic        parado;
  logic        retomar;
  logic [15:0] instr_count;
  logic        erro_timeout;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;
  int exec_seen = 0;

  typedef struct {
    logic [2:0]  opc;
    logic        lsb;
    logic [4:0]  pc;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  sequenciador_busca dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_dado     (imem_dado),
    .OPcode        (OPcode),
    .bit_menos_sig (bit_menos_sig),
    .halt          (halt),
    .jump          (jump),
    .beq           (beq),
    .zero          (zero),
    .exec_valid    (exec_valid),
    .pc            (pc),
    .parado        (parado),
    .retomar       (retomar),
    .instr_count   (instr_count),
    .erro_timeout  (erro_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every commit strobe must match the oldest expectation
  always @(negedge clock) begin
    if (reset_n && exec_valid) begin
      exec_seen++;
      if (sb_q.size() == 0) begin
        chk("exec_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_opcode", {29'd0, OPcode}, {29'd0, e.opc});
        chk("sb_lsb", {31'd0, bit_menos_sig}, {31'd0, e.lsb});
        chk("sb_pc", {27'd0, pc}, {27'd0, e.pc});
        chk("sb_count", {16'd0, instr_count}, {16'd0, e.cnt});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    if (!imem_req) chk("req_wait_expired", 32'd0, 32'd1);
  endtask

  // Fetch one instruction at addr with 'dly' wait cycles, execute it with the
  // given control inputs and check the resulting PC
  task automatic run_instr(input logic [4:0] addr, input logic [7:0] word, input int dly,
                           input logic h, input logic j, input logic b, input logic z,
                           input logic ack_exec, input logic [4:0] exp_next);
    exp_t e;
    wait_req();
    chk("fetch_addr", {27'd0, imem_addr}, {27'd0, addr});
    for (int i = 0; i < dly; i++) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", {27'd0, imem_addr}, {27'd0, addr});
      step();
    end
    chk("req_at_ack", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_dado = word;
    halt = h; jump = j; beq = b; zero = z;
    e.opc = word[7:5]; e.lsb = word[0]; e.pc = addr; e.cnt = 16'(exp_count);
    sb_q.push_back(e);
    step();
    chk("exec_after_ack", {31'd0, exec_valid}, 32'd1);
    chk("req_low_exec", {31'd0, imem_req}, 32'd0);
    if (ack_exec) imem_dado = 8'hFF;
    else imem_ack = 1'b0;
    step();
    imem_ack = 1'b0;
    halt = 1'b0; jump = 1'b0; beq = 1'b0; zero = 1'b0;
    exp_count++;
    chk("next_pc", {27'd0, pc}, {27'd0, exp_next});
    chk("exec_one_cycle", {31'd0, exec_valid}, 32'd0);
    chk("count", {16'd0, instr_count}, exp_count);
    chk("parado_after", {31'd0, parado}, {31'd0, h});
  endtask

  initial begin
    reset_n = 1'b0;
    imem_ack = 1'b0; imem_dado = 8'h00;
    halt = 1'b0; jump = 1'b0; beq = 1'b0; zero = 1'b0; retomar = 1'b0;
    step(); step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_opcode", {29'd0, OPcode}, 32'd0);
    chk("rst_lsb", {31'd0, bit_menos_sig}, 32'd0);
    chk("rst_exec", {31'd0, exec_valid}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    chk("rst_erro", {31'd0, erro_timeout}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("req_cycle1", {31'd0, imem_req}, 32'd1);

    // Basic zero-wait fetch, then program flow through jumps/branches/wrap
    run_instr(5'd0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
    run_instr(5'd1, 8'h04, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4);
    run_instr(5'd4, 8'h60, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    run_instr(5'd5, 8'h42, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2);
    run_instr(5'd2, 8'h4D, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13);
    run_instr(5'd13, 8'h41, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
    run_instr(5'd1, 8'h44, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd30);
    run_instr(5'd30, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31);
    run_instr(5'd31, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    run_instr(5'd0, 8'h01, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
    run_instr(5'd1, 8'h44, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
    run_instr(5'd2, 8'h07, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
    // halt wins over jump
    run_instr(5'd7, 8'h01, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8);

    // Stay halted for 10 cycles, ignoring memory acks
    imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("halt_req_low", {31'd0, imem_req}, 32'd0);
      chk("halt_parado", {31'd0, parado}, 32'd1);
      chk("halt_pc", {27'd0, pc}, 32'd8);
      step();
    end
    imem_ack = 1'b0;
    retomar = 1'b1;
    step();
    retomar = 1'b0;
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", {27'd0, imem_addr}, 32'd8);
    chk("resume_parado", {31'd0, parado}, 32'd0);

    // Reset in the middle of a fetch wait
    step(); step();
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", {27'd0, pc}, 32'd0);
    chk("midrst_count", {16'd0, instr_count}, 32'd0);
    exp_count = 0;
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    run_instr(5'd0, 8'h61, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);

    // No ack at all: fault path or indefinite wait depending on build
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      chk("to_req", {31'd0, imem_req}, 32'd1);
      chk("to_not_parado", {31'd0, parado}, 32'd0);
      step();
    end
    chk("to_parado", {31'd0, parado}, 32'd1);
    chk("to_erro", {31'd0, erro_timeout}, 32'd1);
    chk("to_pc", {27'd0, pc}, 32'd1);
    chk("to_req_low", {31'd0, imem_req}, 32'd0);
    retomar = 1'b1;
    step();
    retomar = 1'b0;
    chk("to_resume_req", {31'd0, imem_req}, 32'd1);
    chk("to_erro_sticky", {31'd0, erro_timeout}, 32'd1);
`else
    for (int i = 0; i < 20; i++) step();
    chk("nto_req", {31'd0, imem_req}, 32'd1);
    chk("nto_parado", {31'd0, parado}, 32'd0);
    chk("nto_erro", {31'd0, erro_timeout}, 32'd0);
    chk("nto_pc", {27'd0, pc}, 32'd1);
`endif

    step();
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("exec_total", exec_seen, 32'd14);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
